multdiv_ctrl: RTL and testbench

Sequencer for the shared multiply/divide datapath: accepts single-cycle `ctrl_MULT` / `ctrl_DIV` start pulses, then loads the product register and steps it once per cycle. In multiply mode it decodes the radix-4 Booth triplet into add/sub/shift selects; in divide mode it issues non-restoring add/sub steps. It raises `data_resultRDY` for one cycle with `data_exception` valid, and is instantiated beside the 65-bit product register, the 32-bit adder and the multiplicand register inside the multdiv unit.

---
 rtl/multdiv_ctrl.sv | 144 ++++++++++++++
 tb/tb_multdiv_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared multiply/divide datapath (radix-4 Booth multiply, non-restoring divide).
// Divide sequencing is built only when MULTDIV_DIV_EN is defined; otherwise ctrl_DIV reports an exception.
module multdiv_ctrl #(
  parameter int MULT_STEPS = 16,
  parameter int DIV_STEPS  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ctrl_MULT,
  input  logic       ctrl_DIV,
  input  logic [2:0] booth_bits,
  input  logic       rem_neg,
  input  logic       divisor_zero,
  input  logic       mult_ovf,
  output logic [1:0] prod_sel,
  output logic       prod_en,
  output logic       mcand_en,
  output logic       add_sub,
  output logic       addend_x2,
  output logic       is_div,
  output logic [5:0] count,
  output logic       busy,
  output logic       data_resultRDY,
  output logic       data_exception
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  localparam logic [5:0] MULT_LAST = 6'(MULT_STEPS - 1);
  localparam logic [5:0] DIV_LAST  = 6'(DIV_STEPS - 1);

  state_t     r_state;
  logic       r_op_div;
  logic       r_exc;
  logic [5:0] r_count;

  logic w_start;
  logic w_start_div;
  logic w_last;

  // Multiply wins when both start pulses arrive together.
  assign w_start     = ctrl_MULT | ctrl_DIV;
  assign w_start_div = ctrl_DIV & ~ctrl_MULT;
  assign w_last      = (r_count == (r_op_div ? DIV_LAST : MULT_LAST));

`ifndef MULTDIV_DIV_EN
  logic w_unused;
  assign w_unused = ^{rem_neg, divisor_zero};
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op_div <= 1'b0;
      r_exc    <= 1'b0;
      r_count  <= 6'd0;
    end else if (w_start) begin
      r_op_div <= w_start_div;
      r_count  <= 6'd0;
`ifdef MULTDIV_DIV_EN
      r_state  <= S_LOAD;
      r_exc    <= 1'b0;
`else
      r_state  <= w_start_div ? S_DONE : S_LOAD;
      r_exc    <= w_start_div;
`endif
    end else begin
      case (r_state)
        S_LOAD: begin
          r_state <= S_RUN;
`ifdef MULTDIV_DIV_EN
          r_exc   <= r_op_div & divisor_zero;
`endif
        end
        S_RUN: begin
          r_count <= r_count + 6'd1;
          if (w_last) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default first so the decode cannot infer a latch.
  always_comb begin
    prod_sel  = 2'b00;
    prod_en   = 1'b0;
    mcand_en  = 1'b0;
    add_sub   = 1'b0;
    addend_x2 = 1'b0;
    case (r_state)
      S_LOAD: begin
        prod_sel = 2'b10;
        prod_en  = 1'b1;
        mcand_en = 1'b1;
      end
      S_RUN: begin
        prod_en = 1'b1;
`ifdef MULTDIV_DIV_EN
        if (r_op_div) begin
          prod_sel = 2'b01;
          add_sub  = (r_count == 6'd0) | ~rem_neg;
        end else begin
`else
        begin
`endif
          // Radix-4 Booth digit: 0, +M, +2M, -2M, -M.
          case (booth_bits)
            3'b001, 3'b010: prod_sel = 2'b01;
            3'b011: begin
              prod_sel  = 2'b01;
              addend_x2 = 1'b1;
            end
            3'b100: begin
              prod_sel  = 2'b01;
              add_sub   = 1'b1;
              addend_x2 = 1'b1;
            end
            3'b101, 3'b110: begin
              prod_sel = 2'b01;
              add_sub  = 1'b1;
            end
            default: prod_sel = 2'b00;
          endcase
        end
      end
      default: ;
    endcase
  end

`ifdef MULTDIV_DIV_EN
  assign is_div = r_op_div;
`else
  assign is_div = 1'b0;
`endif

  assign count          = r_count;
  assign busy           = (r_state == S_LOAD) || (r_state == S_RUN);
  assign data_resultRDY = (r_state == S_DONE);
  assign data_exception = data_resultRDY & (r_op_div ? r_exc : mult_ovf);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: randomized datapath inputs against a cycle-position model.
// Honours MULTDIV_DIV_EN the same way the design does.
`timescale 1ns/1ps
module tb_multdiv_ctrl;

  localparam int MS = 16;
  localparam int DS = 32;
`ifdef MULTDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int SC = 1000;  // position code for the divide-unsupported shortcut

  logic       clk = 1'b0;
  logic       rst;
  logic       ctrl_MULT;
  logic       ctrl_DIV;
  logic [2:0] booth_bits;
  logic       rem_neg;
  logic       divisor_zero;
  logic       mult_ovf;
  logic [1:0] prod_sel;
  logic       prod_en;
  logic       mcand_en;
  logic       add_sub;
  logic       addend_x2;
  logic       is_div;
  logic [5:0] count;
  logic       busy;
  logic       data_resultRDY;
  logic       data_exception;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: position within the current operation (0 = idle, 1 = load, ...).
  int m_t     = 0;
  bit m_div   = 1'b0;
  bit m_exc   = 1'b0;
  bit m_isdiv = 1'b0;
  int m_hold  = 0;

  int booth_force = -1;
  int ovf_force   = -1;

  always #5 clk = ~clk;

  multdiv_ctrl #(.MULT_STEPS(MS), .DIV_STEPS(DS)) dut (
    .clk           (clk),
    .rst           (rst),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .booth_bits    (booth_bits),
    .rem_neg       (rem_neg),
    .divisor_zero  (divisor_zero),
    .mult_ovf      (mult_ovf),
    .prod_sel      (prod_sel),
    .prod_en       (prod_en),
    .mcand_en      (mcand_en),
    .add_sub       (add_sub),
    .addend_x2     (addend_x2),
    .is_div        (is_div),
    .count         (count),
    .busy          (busy),
    .data_resultRDY(data_resultRDY),
    .data_exception(data_exception)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at t=%0d: observed %0d expected %0d", tag, m_t, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check at the falling edge, then advance the model.
  task automatic cyc(input bit m, input bit d, input bit r);
    int n, sel, sub, x2, en, men, cnt, dig;
    bit busy_e, rdy_e, exc_e;
    ctrl_MULT  = m;
    ctrl_DIV   = d;
    rst        = r;
    booth_bits = (booth_force >= 0) ? 3'(booth_force) : 3'($urandom_range(0, 7));
    rem_neg    = 1'($urandom_range(0, 1));
    mult_ovf   = (ovf_force >= 0) ? 1'(ovf_force) : 1'($urandom_range(0, 1));

    n = m_div ? DS : MS;
    sel = 0; sub = 0; x2 = 0; en = 0; men = 0;
    busy_e = 1'b0; rdy_e = 1'b0; exc_e = 1'b0;
    cnt = m_hold;
    if (m_t == SC) begin
      rdy_e = 1'b1; exc_e = 1'b1; cnt = -1;
    end else if (m_t == 1) begin
      sel = 2; en = 1; men = 1; busy_e = 1'b1; cnt = 0;
    end else if (m_t >= 2 && m_t <= n + 1) begin
      en = 1; busy_e = 1'b1; cnt = m_t - 2;
      if (m_div) begin
        sel = 1;
        sub = (m_t == 2) ? 1 : int'(!rem_neg);
      end else begin
        dig = int'(booth_bits[1]) + int'(booth_bits[0]) - 2 * int'(booth_bits[2]);
        sel = (dig != 0) ? 1 : 0;
        sub = (dig < 0) ? 1 : 0;
        x2  = (dig == 2 || dig == -2) ? 1 : 0;
      end
    end else if (m_t == n + 2) begin
      rdy_e = 1'b1; cnt = n;
      exc_e = m_div ? m_exc : mult_ovf;
    end

    @(negedge clk);
    check("prod_sel",  32'(prod_sel),  32'(sel));
    check("prod_en",   32'(prod_en),   32'(en));
    check("mcand_en",  32'(mcand_en),  32'(men));
    check("add_sub",   32'(add_sub),   32'(sub));
    check("addend_x2", 32'(addend_x2), 32'(x2));
    check("busy",      32'(busy),      32'(busy_e));
    check("rdy",       32'(data_resultRDY), 32'(rdy_e));
    check("exception", 32'(data_exception), 32'(exc_e));
    check("is_div",    32'(is_div),    32'(m_isdiv));
    if (cnt >= 0) check("count", 32'(count), 32'(cnt));
    @(posedge clk); #1;

    if (r) begin
      m_t = 0; m_div = 1'b0; m_isdiv = 1'b0; m_exc = 1'b0; m_hold = 0;
    end else if (m || d) begin
      m_div   = d && !m;
      m_isdiv = DIV_EN && m_div;
      m_t     = (m_div && !DIV_EN) ? SC : 1;
    end else if (m_t == SC) begin
      m_t = 0; m_hold = -1;
    end else if (m_t == 1) begin
      m_exc = m_div && divisor_zero;
      m_t   = 2;
    end else if (m_t >= 2 && m_t <= n + 1) begin
      m_t++;
    end else if (m_t == n + 2) begin
      m_t = 0; m_hold = n;
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; booth_bits = 3'd0;
    rem_neg = 1'b0; divisor_zero = 1'b0; mult_ovf = 1'b0;
    @(posedge clk); #1;
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    idle(2);

    // Multiply with shift-only Booth bits, overflow low then high.
    booth_force = 0; ovf_force = 0;
    cyc(1'b1, 1'b0, 1'b0); idle(20);
    ovf_force = 1;
    cyc(1'b1, 1'b0, 1'b0); idle(20);
    booth_force = -1; ovf_force = -1;

    // Booth decode sweep inside RUN.
    cyc(1'b1, 1'b0, 1'b0); idle(1);
    for (int k = 0; k < 8; k++) begin
      booth_force = k; cyc(1'b0, 1'b0, 1'b0);
    end
    booth_force = -1; idle(12);

    // Simultaneous start: multiply wins.
    cyc(1'b1, 1'b1, 1'b0); idle(20);

    // Back-to-back restart in the DONE cycle.
    cyc(1'b1, 1'b0, 1'b0); idle(17);
    cyc(1'b1, 1'b0, 1'b0); idle(20);

    // Abort a multiply at count 5.
    cyc(1'b1, 1'b0, 1'b0); idle(6);
`ifdef MULTDIV_DIV_EN
    cyc(1'b0, 1'b1, 1'b0); idle(36);
`else
    cyc(1'b1, 1'b0, 1'b0); idle(20);
`endif

    // Reset at count 9 while a start pulse is also present.
    cyc(1'b1, 1'b0, 1'b0); idle(10);
    cyc(1'b1, 1'b0, 1'b1); idle(3);

    // Divide with divisor zero, then nonzero (shortcut exception without divide support).
    divisor_zero = 1'b1;
    cyc(1'b0, 1'b1, 1'b0); idle(36);
    divisor_zero = 1'b0;
    cyc(1'b0, 1'b1, 1'b0); idle(36);

    // Multiply after a divide restores normal sequencing.
    cyc(1'b1, 1'b0, 1'b0); idle(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
